prog_sequencer: RTL and testbench
=================================

# prog_sequencer

Program sequencer that stores a short program of 10-bit words, entered from the switch bus, and replays it into the processor core's external-data path. It sits between the switch input and the tri-state external bus buffer. It serves one word each time the core samples external data, and gates core advancement through run, single-step and pause modes. The goal is that whole programs, immediates included, execute without manual switch entry for every instruction.

## Interface
Parameters:
- DEPTH, 16: program memory entries (power of two, ≥2)
- W, 10: word width (matches the datapath bus)

Ports (AW = $clog2(DEPTH)+1):
- CLK  in  1  single clock; everything is sampled on its rising edge
- RSTb  in  1  synchronous, active-low reset
- IN_DATA  in  W  word to append to the program
- LOAD  in  1  one-cycle pulse: append IN_DATA
- CLEAR  in  1  one-cycle pulse: return to IDLE; in IDLE, erase the program
- RUN  in  1  one-cycle pulse: run continuously
- STEP  in  1  one-cycle pulse: execute one instruction
- HALT  in  1  one-cycle pulse: pause after the current cycle
- WORD_REQ  in  1  core samples external data this cycle (asserted with Ext)
- DONE  in  1  core finished an instruction (counter clear)
- DATA_OUT  out  W  word presented to the bus buffer; 0 when DATA_VALID=0
- DATA_VALID  out  1  DATA_OUT holds a program word
- CORE_EN  out  1  core may advance this cycle
- FIN  out  1  program completed
- ERR  out  1  sticky error flag
- WP_CNT  out  AW  program length (words loaded)
- PC  out  AW  index of the next word to serve

## Operation
- Storage: DEPTH×W register array. WP = write pointer (exposed as WP_CNT). RP = read pointer (exposed as PC). Reads are non-destructive, so a loaded program can be rerun.
- DATA_OUT = mem[RP] when DATA_VALID, else 0.
- DATA_VALID = (state ∈ {RUN, STEP}) && RP < WP.
- A word is consumed when WORD_REQ && DATA_VALID; RP increments by 1.
- States: IDLE, RUN, STEP, PAUSE, FINISH. Input priority each cycle: CLEAR > HALT > RUN > STEP > DONE.
- IDLE:
  - LOAD with WP<DEPTH writes mem[WP] and increments WP.
  - LOAD with WP==DEPTH drops the word and sets ERR.
  - CLEAR sets WP=0 and RP=0.
  - RUN or STEP with WP≠0 sets RP=0 and enters RUN or STEP respectively.
  - RUN or STEP with WP==0 is ignored.
- RUN: CORE_EN=1.
  - DONE with RP==WP enters FINISH.
  - HALT enters PAUSE.
- STEP: CORE_EN=1.
  - DONE enters PAUSE, or FINISH if RP==WP.
  - HALT enters PAUSE.
- PAUSE: CORE_EN=0. RUN enters RUN, STEP enters STEP. RP is kept.
- FINISH: CORE_EN=0, FIN=1. CLEAR enters IDLE with RP=0 and WP kept, so the program can be rerun.
- CLEAR from RUN, STEP or PAUSE enters IDLE with RP=0 and WP kept.
- LOAD outside IDLE is ignored, with no ERR.
- Underflow: WORD_REQ while in RUN/STEP with DATA_VALID=0 sets ERR. RP is unchanged and DATA_OUT=0.
- ERR is cleared only by CLEAR or reset.
- DONE in IDLE, PAUSE or FINISH is ignored.

## Timing
- Reset (RSTb=0 at a CLK edge): state IDLE, WP=RP=0. All outputs 0: DATA_OUT, DATA_VALID, CORE_EN, FIN, ERR, WP_CNT, PC. Memory contents are not reset.
- Reset mid-run behaves identically and discards the program length.
- LOAD at edge n: mem and WP_CNT updated after edge n.
- RUN/STEP pulse at edge n: state, CORE_EN and DATA_VALID are high in the cycle after edge n.
- Serving is zero-latency: DATA_OUT is valid in the same cycle WORD_REQ is sampled. PC and DATA_OUT advance after that edge.
- Back-to-back WORD_REQ in consecutive cycles is supported, one word per cycle.
- HALT at edge n: CORE_EN=0 from the cycle after edge n.
- HALT and DONE at the same edge: HALT wins and the state becomes PAUSE. RP reflects any word consumed at that edge.
- HALT and WORD_REQ at the same edge: the word is consumed.
- FIN rises one cycle after the final DONE.

## Configuration
- SEQ_LOOP_EN defined: in RUN, DONE with RP==WP sets RP=0 and stays in RUN. The program loops until HALT or CLEAR, FINISH is reachable only via STEP, and FIN stays 0 in RUN.
- SEQ_LOOP_EN undefined: behaviour as specified above (RUN ends in FINISH).

## Test plan
- Reset, then LOAD 0x040, 0x155, 0x2AA, then RUN; WORD_REQ in 3 consecutive cycles → DATA_OUT 0x040, 0x155, 0x2AA; PC 0→3; DONE then → FIN=1, CORE_EN=0.
- DEPTH=16: 17 LOADs in IDLE → WP_CNT=16, ERR=1, mem[15] unchanged by the 17th word; CLEAR → ERR=0, WP_CNT=0.
- 2-word program, STEP, WORD_REQ, DONE → state PAUSE, PC=1, CORE_EN=0; STEP, WORD_REQ, DONE → FIN=1.
- RUN with 1-word program; WORD_REQ twice → second cycle DATA_VALID=0, DATA_OUT=0, ERR=1, PC stays 1.
- HALT and DONE at the same edge mid-run → PAUSE, CORE_EN=0; RUN → resumes with the same PC.
- SEQ_LOOP_EN: 2-word program, RUN, consume both words, DONE → PC=0, still RUN, DATA_OUT=mem[0]; HALT → PAUSE.

Source files
------------

// File: rtl/prog_sequencer.sv
// prog_sequencer
//   Stores a short program of W-bit words entered from the switch bus and
//   replays it, one word per core sample, into the external-data path.
//   Run, single-step and pause modes gate core advancement.
//
// Optional build macro:
//   SEQ_LOOP_EN - in RUN, DONE at the end of the program rewinds PC to 0 and
//                 keeps running instead of entering FINISH.
//
// Ports:
//   CLK        clock, all state sampled on rising edge
//   RSTb       synchronous active-low reset
//   IN_DATA    word to append to the program
//   LOAD       pulse: append IN_DATA (IDLE only)
//   CLEAR      pulse: return to IDLE; in IDLE erase the program
//   RUN        pulse: run continuously
//   STEP       pulse: execute one instruction
//   HALT       pulse: pause
//   WORD_REQ   core samples external data this cycle
//   DONE       core finished an instruction
//   DATA_OUT   word presented to the bus buffer (0 when not valid)
//   DATA_VALID DATA_OUT holds a program word
//   CORE_EN    core may advance this cycle
//   FIN        program completed
//   ERR        sticky error (overflow on load, underflow on serve)
//   WP_CNT     program length
//   PC         index of the next word to serve
module prog_sequencer #(
  parameter int DEPTH = 16,
  parameter int W     = 10,
  localparam int AW   = $clog2(DEPTH) + 1
) (
  input  logic          CLK,
  input  logic          RSTb,
  input  logic [W-1:0]  IN_DATA,
  input  logic          LOAD,
  input  logic          CLEAR,
  input  logic          RUN,
  input  logic          STEP,
  input  logic          HALT,
  input  logic          WORD_REQ,
  input  logic          DONE,
  output logic [W-1:0]  DATA_OUT,
  output logic          DATA_VALID,
  output logic          CORE_EN,
  output logic          FIN,
  output logic          ERR,
  output logic [AW-1:0] WP_CNT,
  output logic [AW-1:0] PC
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_RUN    = 3'd1,
    S_STEP   = 3'd2,
    S_PAUSE  = 3'd3,
    S_FINISH = 3'd4
  } state_t;

  state_t        state_q, state_d;
  logic [AW-1:0] wp_q, wp_d;
  logic [AW-1:0] rp_q, rp_d;
  logic          err_q, err_d;
  logic [W-1:0]  mem_q [DEPTH];

  logic active;
  logic valid;
  logic full;
  logic wr_en;
  logic consume;
  logic underflow;

  assign active    = (state_q == S_RUN) || (state_q == S_STEP);
  assign valid     = active && (rp_q < wp_q);
  assign full      = (wp_q == AW'(DEPTH));
  // CLEAR outranks LOAD, so a simultaneous LOAD is dropped.
  assign wr_en     = (state_q == S_IDLE) && LOAD && !CLEAR && !full;
  assign consume   = WORD_REQ && valid;
  assign underflow = WORD_REQ && active && !valid;

  always_comb begin
    state_d = state_q;
    wp_d    = wp_q;
    rp_d    = rp_q;
    err_d   = err_q;
    case (state_q)
      S_IDLE: begin
        if (CLEAR) begin
          wp_d  = '0;
          rp_d  = '0;
          err_d = 1'b0;
        end else begin
          if (LOAD) begin
            if (full) err_d = 1'b1;
            else      wp_d  = wp_q + AW'(1);
          end
          // An empty program cannot be started.
          if ((RUN || STEP) && (wp_q != '0)) begin
            rp_d    = '0;
            state_d = RUN ? S_RUN : S_STEP;
          end
        end
      end
      S_RUN, S_STEP: begin
        // Word consumption is independent of the mode change at this edge.
        if (consume)   rp_d  = rp_q + AW'(1);
        if (underflow) err_d = 1'b1;
        if (CLEAR) begin
          state_d = S_IDLE;
          rp_d    = '0;
          err_d   = 1'b0;
        end else if (HALT) begin
          state_d = S_PAUSE;
        end else if (DONE) begin
          if (state_q == S_RUN) begin
            if (rp_q == wp_q) begin
`ifdef SEQ_LOOP_EN
              rp_d = '0;
`else
              state_d = S_FINISH;
`endif
            end
          end else begin
            state_d = (rp_q == wp_q) ? S_FINISH : S_PAUSE;
          end
        end
      end
      S_PAUSE: begin
        if (CLEAR) begin
          state_d = S_IDLE;
          rp_d    = '0;
          err_d   = 1'b0;
        end else if (RUN) begin
          state_d = S_RUN;
        end else if (STEP) begin
          state_d = S_STEP;
        end
      end
      S_FINISH: begin
        if (CLEAR) begin
          state_d = S_IDLE;
          rp_d    = '0;
          err_d   = 1'b0;
        end
      end
      default: begin
        state_d = S_IDLE;
        rp_d    = '0;
      end
    endcase
  end

  always_ff @(posedge CLK) begin
    if (!RSTb) begin
      state_q <= S_IDLE;
      wp_q    <= '0;
      rp_q    <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      wp_q    <= wp_d;
      rp_q    <= rp_d;
      err_q   <= err_d;
    end
  end

  // Program storage keeps its contents through reset.
  always_ff @(posedge CLK) begin
    if (wr_en) mem_q[wp_q[AW-2:0]] <= IN_DATA;
  end

  assign DATA_VALID = valid;
  assign DATA_OUT   = valid ? mem_q[rp_q[AW-2:0]] : '0;
  assign CORE_EN    = active;
  assign FIN        = (state_q == S_FINISH);
  assign ERR        = err_q;
  assign WP_CNT     = wp_q;
  assign PC         = rp_q;

endmodule

// File: tb/tb_prog_sequencer.sv
// Self-checking bench for prog_sequencer: program words are tracked in a
// model memory, queued when a program is started and popped as the core
// requests them.
module tb_prog_sequencer;
  localparam int DEPTH = 16;
  localparam int W     = 10;
  localparam int AW    = $clog2(DEPTH) + 1;

  logic          CLK = 1'b0;
  logic          RSTb;
  logic [W-1:0]  IN_DATA;
  logic          LOAD, CLEAR, RUN, STEP, HALT, WORD_REQ, DONE;
  logic [W-1:0]  DATA_OUT;
  logic          DATA_VALID, CORE_EN, FIN, ERR;
  logic [AW-1:0] WP_CNT, PC;

  prog_sequencer #(.DEPTH(DEPTH), .W(W)) dut (
    .CLK(CLK), .RSTb(RSTb), .IN_DATA(IN_DATA), .LOAD(LOAD), .CLEAR(CLEAR),
    .RUN(RUN), .STEP(STEP), .HALT(HALT), .WORD_REQ(WORD_REQ), .DONE(DONE),
    .DATA_OUT(DATA_OUT), .DATA_VALID(DATA_VALID), .CORE_EN(CORE_EN),
    .FIN(FIN), .ERR(ERR), .WP_CNT(WP_CNT), .PC(PC)
  );

  always #5 CLK = ~CLK;

  int n_tests = 0;
  int n_fail  = 0;
  logic [W-1:0] model_mem [DEPTH];
  int wp_m = 0;
  logic [W-1:0] exp_q [$];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic do_load(input logic [W-1:0] d);
    IN_DATA = d;
    LOAD = 1'b1;
    tick();
    LOAD = 1'b0;
    if (wp_m < DEPTH) begin
      model_mem[wp_m] = d;
      wp_m++;
    end
  endtask

  task automatic do_clear();
    CLEAR = 1'b1;
    tick();
    CLEAR = 1'b0;
    exp_q.delete();
  endtask

  task automatic erase();
    do_clear();
    do_clear();
    wp_m = 0;
  endtask

  task automatic start(input bit step_mode);
    if (step_mode) STEP = 1'b1; else RUN = 1'b1;
    tick();
    STEP = 1'b0;
    RUN = 1'b0;
    exp_q.delete();
    for (int i = 0; i < wp_m; i++) exp_q.push_back(model_mem[i]);
  endtask

  task automatic serve(input string tag);
    logic [W-1:0] e;
    check({tag, "_valid"}, DATA_VALID, 1);
    if (exp_q.size() == 0) begin
      check({tag, "_sb_empty"}, 1, 0);
    end else begin
      e = exp_q.pop_front();
      check({tag, "_data"}, DATA_OUT, e);
    end
    WORD_REQ = 1'b1;
    tick();
    WORD_REQ = 1'b0;
  endtask

  task automatic pulse_done();
    DONE = 1'b1;
    tick();
    DONE = 1'b0;
  endtask

  initial begin
    RSTb = 1'b0; IN_DATA = '0; LOAD = 0; CLEAR = 0; RUN = 0; STEP = 0;
    HALT = 0; WORD_REQ = 0; DONE = 0;
    tick(); tick();
    RSTb = 1'b1;
    check("rst_data",  DATA_OUT, 0);
    check("rst_valid", DATA_VALID, 0);
    check("rst_core",  CORE_EN, 0);
    check("rst_fin",   FIN, 0);
    check("rst_err",   ERR, 0);
    check("rst_wp",    WP_CNT, 0);
    check("rst_pc",    PC, 0);

    // Basic run of three words.
    do_load(10'h040); do_load(10'h155); do_load(10'h2AA);
    check("t1_wp", WP_CNT, 3);
    check("t1_core_idle", CORE_EN, 0);
    start(0);
    check("t1_core", CORE_EN, 1);
    check("t1_pc0", PC, 0);
    for (int i = 0; i < 3; i++) begin
      check("t1_pc", PC, i);
      serve("t1");
    end
    check("t1_pc3", PC, 3);
    check("t1_novalid", DATA_VALID, 0);
    pulse_done();
`ifdef SEQ_LOOP_EN
    check("t1_loop_fin", FIN, 0);
    check("t1_loop_pc", PC, 0);
    check("t1_loop_core", CORE_EN, 1);
`else
    check("t1_fin", FIN, 1);
    check("t1_core_end", CORE_EN, 0);
`endif
    check("t1_err", ERR, 0);

    // CLEAR out of RUN/FINISH keeps the program, second CLEAR erases it.
    do_clear();
    check("t2_wp_kept", WP_CNT, 3);
    check("t2_pc", PC, 0);
    check("t2_fin", FIN, 0);
    erase();
    check("t2_wp_erased", WP_CNT, 0);
    for (int i = 0; i < DEPTH; i++) do_load(W'(10'h100 + i));
    check("t2_noerr_full", ERR, 0);
    do_load(10'h3FF);
    check("t2_wp_full", WP_CNT, DEPTH);
    check("t2_err", ERR, 1);
    start(0);
    for (int i = 0; i < DEPTH; i++) serve("t2");
    do_clear();
    check("t2_err_clr", ERR, 0);
    check("t2_wp_after", WP_CNT, DEPTH);
    erase();
    check("t2_wp_zero", WP_CNT, 0);

    // Single-step.
    do_load(10'h011); do_load(10'h022);
    start(1);
    check("t3_core", CORE_EN, 1);
    serve("t3a");
    pulse_done();
    check("t3_pc1", PC, 1);
    check("t3_core_pause", CORE_EN, 0);
    check("t3_valid_pause", DATA_VALID, 0);
    check("t3_data_pause", DATA_OUT, 0);
    check("t3_fin_pause", FIN, 0);
    STEP = 1'b1; tick(); STEP = 1'b0;
    check("t3_core2", CORE_EN, 1);
    serve("t3b");
    pulse_done();
    check("t3_fin", FIN, 1);

    // Underflow.
    erase();
    do_load(10'h2A5);
    start(0);
    serve("t4");
    WORD_REQ = 1'b1;
    check("t4_uf_valid", DATA_VALID, 0);
    check("t4_uf_data", DATA_OUT, 0);
    tick();
    WORD_REQ = 1'b0;
    check("t4_err", ERR, 1);
    check("t4_pc", PC, 1);

    // HALT + DONE + WORD_REQ at one edge.
    erase();
    check("t5_err_clr", ERR, 0);
    do_load(10'h0F0); do_load(10'h10F); do_load(10'h3C3);
    start(0);
    serve("t5a");
    check("t5_data_b", DATA_OUT, exp_q.pop_front());
    HALT = 1'b1; DONE = 1'b1; WORD_REQ = 1'b1;
    tick();
    HALT = 1'b0; DONE = 1'b0; WORD_REQ = 1'b0;
    check("t5_core_pause", CORE_EN, 0);
    check("t5_pc_pause", PC, 2);
    check("t5_fin", FIN, 0);
    RUN = 1'b1; tick(); RUN = 1'b0;
    check("t5_core_resume", CORE_EN, 1);
    check("t5_pc_resume", PC, 2);
    serve("t5c");

    // End of program in RUN: loop or finish.
    erase();
    do_load(10'h0AA); do_load(10'h155);
    start(0);
    serve("t6a"); serve("t6b");
    pulse_done();
`ifdef SEQ_LOOP_EN
    check("t6_pc0", PC, 0);
    check("t6_core", CORE_EN, 1);
    check("t6_fin", FIN, 0);
    check("t6_data0", DATA_OUT, 10'h0AA);
    HALT = 1'b1; tick(); HALT = 1'b0;
    check("t6_halt", CORE_EN, 0);
`else
    check("t6_fin", FIN, 1);
    RUN = 1'b1; tick(); RUN = 1'b0;
    check("t6_fin_hold", FIN, 1);
    check("t6_core_hold", CORE_EN, 0);
`endif

    // LOAD ignored outside IDLE, then reset mid-run.
    erase();
    do_load(10'h123); do_load(10'h321);
    start(0);
    serve("t7");
    IN_DATA = 10'h3FF; LOAD = 1'b1; tick(); LOAD = 1'b0;
    check("t7_load_ign", WP_CNT, 2);
    check("t7_load_noerr", ERR, 0);
    RSTb = 1'b0; tick(); RSTb = 1'b1;
    check("t7_rst_wp", WP_CNT, 0);
    check("t7_rst_pc", PC, 0);
    check("t7_rst_core", CORE_EN, 0);
    check("t7_rst_valid", DATA_VALID, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
